cnn_pixel_streamer: RTL

- Frame source that drives the pixel-input side of cnn_top.
- A host or bench preloads one IMG_W x IMG_H frame into an internal register-array frame buffer. A start pulse then makes the block stream the frame in raster order, one pixel per cycle, as a valid/data pair that connects directly to cnn_top in_valid/pixel_in.
- Adds a pause stall, start-of-line and end-of-frame markers, and a done pulse.

---
 rtl/cnn_pixel_streamer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cnn_pixel_streamer.sv
// Frame source for cnn_top: a preloaded IMG_W x IMG_H buffer streamed in raster order
// with pause, start-of-line/end-of-frame markers and a done pulse; row gaps via STREAMER_LINE_GAP_EN.
module cnn_pixel_streamer #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 4,
  parameter int IMG_H    = 2,
  parameter int ADDR_W   = 3,
  parameter int LINE_GAP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     start,
  input  logic                     pause,
  output logic                     busy,
  output logic                     done,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] pixel_out,
  output logic                     out_sol,
  output logic                     out_eof
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]  NPIX     = (ADDR_W+1)'(IMG_W * IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd3;
`ifdef STREAMER_LINE_GAP_EN
  localparam logic [1:0] S_GAP    = 2'd2;
  localparam int GAP_W = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_GAP - 1);
  logic [GAP_W-1:0] gap_cnt;
`endif

  logic [1:0]                state;
  logic [ADDR_W-1:0]         rd_ptr;
  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic                      frame_sent;
  logic signed [DATA_W-1:0]  mem [DEPTH];
  logic                      at_eol;
  logic                      at_eof;

  assign at_eol = (col == COL_LAST);
  assign at_eof = at_eol && (row == ROW_LAST);

  // Buffer is writable only while idle, so a frame can never change under the reader.
  always_ff @(posedge clk) begin
    if (wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < NPIX))
      mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      col        <= '0;
      row        <= '0;
      frame_sent <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_sol    <= 1'b0;
      out_eof    <= 1'b0;
      pixel_out  <= '0;
`ifdef STREAMER_LINE_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_eof   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_STREAM;
            busy       <= 1'b1;
            rd_ptr     <= '0;
            col        <= '0;
            row        <= '0;
            frame_sent <= 1'b0;
          end
        end
        S_STREAM: begin
          // The cycle after the eof pixel carries done, so the done cycle itself is non-idle.
          if (frame_sent) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (!pause) begin
            out_valid <= 1'b1;
            pixel_out <= mem[rd_ptr];
            out_sol   <= (col == '0);
            out_eof   <= at_eof;
            rd_ptr    <= rd_ptr + 1'b1;
            if (at_eol) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (at_eof)
              frame_sent <= 1'b1;
`ifdef STREAMER_LINE_GAP_EN
            else if (at_eol && (LINE_GAP > 0))
              state <= S_GAP;
`endif
          end
        end
`ifdef STREAMER_LINE_GAP_EN
        S_GAP: begin
          if (!pause) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              state   <= S_STREAM;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
`endif
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
